// File: rtl/t01_keypad_scan.sv
// t01_keypad_scan: 4x4 keypad column scanner with debounce, ASCII decode and a one-cycle keyvalid pulse.
// Optional auto-repeat while a key stays held is enabled by defining T01_KEYPAD_REPEAT_EN.
module t01_keypad_scan #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4
`ifdef T01_KEYPAD_REPEAT_EN
   ,parameter int REPEAT_TICKS = 256
`endif
) (
   input  logic       clk,
   input  logic       nRST,
   input  logic       en,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [7:0] data,
   output logic       keyvalid,
   output logic [2:0] dbg_state
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W = $clog2(DEBOUNCE + 1);

   // Encoding is visible on dbg_state, so the values are fixed.
   typedef enum logic [2:0] {
      S_SCAN     = 3'd0,
      S_DEBOUNCE = 3'd1,
      S_EMIT     = 3'd2,
      S_HOLD     = 3'd3,
      S_RELEASE  = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         rs1_q, rs_q;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [1:0]         col_q, col_d;
   logic [DEB_W-1:0]   deb_q, deb_d, deb_inc;
   logic [3:0]         key_rows_q, key_rows_d;
   logic [3:0]         cols_q, cols_d;
   logic [7:0]         data_q, data_d;
   logic               keyvalid_q, keyvalid_d;
   logic               tick;
`ifdef T01_KEYPAD_REPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
   logic [RPT_W-1:0]   rpt_q, rpt_d, rpt_inc;
`endif

   // Lowest-indexed active row wins when several rows are sensed.
   function automatic logic [1:0] low_row(input logic [3:0] r);
      if (r[0])      return 2'd0;
      else if (r[1]) return 2'd1;
      else if (r[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   function automatic logic [7:0] key_ascii(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: key_ascii = 8'h31;  4'h1: key_ascii = 8'h32;
         4'h2: key_ascii = 8'h33;  4'h3: key_ascii = 8'h41;
         4'h4: key_ascii = 8'h34;  4'h5: key_ascii = 8'h35;
         4'h6: key_ascii = 8'h36;  4'h7: key_ascii = 8'h42;
         4'h8: key_ascii = 8'h37;  4'h9: key_ascii = 8'h38;
         4'hA: key_ascii = 8'h39;  4'hB: key_ascii = 8'h43;
         4'hC: key_ascii = 8'h2A;  4'hD: key_ascii = 8'h30;
         4'hE: key_ascii = 8'h23;  default: key_ascii = 8'h44;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      deb_d      = deb_q;
      key_rows_d = key_rows_q;
      data_d     = data_q;
      keyvalid_d = 1'b0;
      tick       = (div_q == DIV_W'(SCAN_DIV - 1));
      div_d      = tick ? '0 : div_q + DIV_W'(1);
      deb_inc    = deb_q + DEB_W'(1);
`ifdef T01_KEYPAD_REPEAT_EN
      rpt_d      = rpt_q;
      rpt_inc    = rpt_q + RPT_W'(1);
`endif

      case (state_q)
         S_SCAN: begin
            if (tick) begin
               if (rs_q == 4'h0) begin
                  col_d = col_q + 2'd1;
               end else begin
                  key_rows_d = rs_q;
                  deb_d      = '0;
                  state_d    = S_DEBOUNCE;
               end
            end
         end
         S_DEBOUNCE: begin
            if (tick) begin
               if (rs_q == key_rows_q) begin
                  deb_d = deb_inc;
                  if (deb_inc >= DEB_W'(DEBOUNCE - 1)) state_d = S_EMIT;
               end else begin
                  state_d = S_SCAN;
                  col_d   = col_q + 2'd1;
               end
            end
         end
         S_EMIT: begin
            data_d     = key_ascii(low_row(key_rows_q), col_q);
            keyvalid_d = 1'b1;
            state_d    = S_HOLD;
`ifdef T01_KEYPAD_REPEAT_EN
            rpt_d      = '0;
`endif
         end
         S_HOLD: begin
            if (tick) begin
               if (rs_q == 4'h0) begin
                  deb_d   = '0;
                  state_d = S_RELEASE;
`ifdef T01_KEYPAD_REPEAT_EN
                  rpt_d   = '0;
               end else if (rpt_inc >= RPT_W'(REPEAT_TICKS)) begin
                  keyvalid_d = 1'b1;
                  rpt_d      = '0;
               end else begin
                  rpt_d = rpt_inc;
`endif
               end
            end
         end
         S_RELEASE: begin
            if (tick) begin
               if (rs_q == 4'h0) begin
                  deb_d = deb_inc;
                  if (deb_inc >= DEB_W'(DEBOUNCE - 1)) begin
                     deb_d   = '0;
                     state_d = S_SCAN;
                     col_d   = col_q + 2'd1;
                  end
               end else begin
                  state_d = S_HOLD;
`ifdef T01_KEYPAD_REPEAT_EN
                  rpt_d   = '0;
`endif
               end
            end
         end
         default: state_d = S_SCAN;
      endcase

      // Disabled scanning parks everything except the last decoded key.
      if (!en) begin
         state_d    = S_SCAN;
         div_d      = '0;
         col_d      = 2'd0;
         deb_d      = '0;
         keyvalid_d = 1'b0;
`ifdef T01_KEYPAD_REPEAT_EN
         rpt_d      = '0;
`endif
      end

      cols_d = en ? (4'b0001 << col_d) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (!nRST) begin
         state_q    <= S_SCAN;
         rs1_q      <= 4'h0;
         rs_q       <= 4'h0;
         div_q      <= '0;
         col_q      <= 2'd0;
         deb_q      <= '0;
         key_rows_q <= 4'h0;
         cols_q     <= 4'h0;
         data_q     <= 8'h00;
         keyvalid_q <= 1'b0;
`ifdef T01_KEYPAD_REPEAT_EN
         rpt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         rs1_q      <= rows;
         rs_q       <= rs1_q;
         div_q      <= div_d;
         col_q      <= col_d;
         deb_q      <= deb_d;
         key_rows_q <= key_rows_d;
         cols_q     <= cols_d;
         data_q     <= data_d;
         keyvalid_q <= keyvalid_d;
`ifdef T01_KEYPAD_REPEAT_EN
         rpt_q      <= rpt_d;
`endif
      end
   end

   assign cols      = cols_q;
   assign data      = data_q;
   assign keyvalid  = keyvalid_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_t01_keypad_scan.sv
// Bench for t01_keypad_scan: a keypad model driving rows from cols, a table-based key model,
// and a per-cycle monitor checking pulses, data stability and column drive.
module tb_t01_keypad_scan;

   localparam int SCAN_DIV = 4;
`ifdef T01_KEYPAD_REPEAT_EN
   localparam int RPT          = 8;
   localparam int CLEAN_EXP    = 6;
   localparam int REPEAT_EXP   = 3;
`else
   localparam int RPT          = 0;
   localparam int CLEAN_EXP    = 1;
   localparam int REPEAT_EXP   = 1;
`endif
   localparam logic [2:0] ST_SCAN     = 3'd0;
   localparam logic [2:0] ST_DEBOUNCE = 3'd1;

   logic       clk = 1'b0;
   logic       nRST = 1'b0;
   logic       en = 1'b0;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [7:0] data;
   logic       keyvalid;
   logic [2:0] dbg_state;

   logic       key_down = 1'b0;
   logic [1:0] key_col = 2'd0;
   logic [3:0] key_mask = 4'h0;
   logic [3:0] glitch_rows = 4'h0;

   logic [7:0] key_map [4][4] = '{'{8'h31, 8'h32, 8'h33, 8'h41},
                                  '{8'h34, 8'h35, 8'h36, 8'h42},
                                  '{8'h37, 8'h38, 8'h39, 8'h43},
                                  '{8'h2A, 8'h30, 8'h23, 8'h44}};

   int         total = 0;
   int         bad = 0;
   int         pulse_cnt = 0;
   logic       exp_armed = 1'b0;
   logic [7:0] exp_data = 8'h00;
   logic       mon_on = 1'b0;
   logic       en_e = 1'b0;
   logic       nrst_e = 1'b0;
   logic       prev_kv = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always #5 clk = ~clk;

   // A held key connects its row lines to its column drive; glitch_rows models bounce/noise.
   always_comb rows = glitch_rows | ((key_down && cols[key_col]) ? key_mask : 4'h0);

   t01_keypad_scan #(
      .SCAN_DIV(SCAN_DIV),
      .DEBOUNCE(3)
`ifdef T01_KEYPAD_REPEAT_EN
      ,.REPEAT_TICKS(8)
`endif
   ) dut (
      .clk(clk),
      .nRST(nRST),
      .en(en),
      .rows(rows),
      .cols(cols),
      .data(data),
      .keyvalid(keyvalid),
      .dbg_state(dbg_state)
   );

   function automatic logic [7:0] model_key(input logic [3:0] mask, input logic [1:0] col);
      for (int r = 0; r < 4; r++) if (mask[r]) return key_map[r][col];
      return 8'h00;
   endfunction

   // hold = cycles/SCAN_DIV the key stays down after the first pulse is seen;
   // the HOLD state samples the key on hold+1 ticks.
   function automatic int model_pulses(input int hold);
`ifdef T01_KEYPAD_REPEAT_EN
      return 1 + (hold + 1) / RPT;
`else
      return 1 + hold * RPT;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      en_e   <= en;
      nrst_e <= nRST;
   end

   always @(negedge clk) begin
      if (mon_on) begin
         check("cols_onehot", {31'd0, $onehot0(cols)}, 32'd1);
         if (!en_e || !nrst_e) check("cols_idle", {28'd0, cols}, 32'd0);
         if (keyvalid) begin
            check("pulse_allowed", {31'd0, exp_armed}, 32'd1);
            check("pulse_data", {24'd0, data}, {24'd0, exp_data});
            check("pulse_gap", {31'd0, prev_kv}, 32'd0);
            pulse_cnt++;
         end else if (nrst_e) begin
            check("data_steady", {24'd0, data}, {24'd0, prev_data});
         end
         prev_kv   = keyvalid;
         prev_data = data;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_pulses(input string name, input int target);
      int n = 0;
      while (pulse_cnt < target && n < 400) begin
         cyc(1);
         n++;
      end
      check(name, {31'd0, pulse_cnt >= target}, 32'd1);
   endtask

   task automatic wait_state(input string name, input logic [2:0] st);
      int n = 0;
      while (dbg_state !== st && n < 400) begin
         cyc(1);
         n++;
      end
      check(name, {29'd0, dbg_state}, {29'd0, st});
   endtask

   task automatic wait_col0(input string name);
      int n = 0;
      while (cols !== 4'b0001 && n < 400) begin
         cyc(1);
         n++;
      end
      check(name, {28'd0, cols}, 32'd1);
   endtask

   task automatic do_press(input string name, input logic [3:0] mask, input logic [1:0] col,
                           input int hold, output int got);
      int         base;
      logic [7:0] want;
      logic [1:0] nc;
      logic [3:0] want_cols;
      want      = model_key(mask, col);
      nc        = col + 2'd1;
      want_cols = 4'b0001 << nc;
      base      = pulse_cnt;
      exp_data  = want;
      exp_armed = 1'b1;
      key_mask  = mask;
      key_col   = col;
      key_down  = 1'b1;
      wait_pulses({name, "_first"}, base + 1);
      check({name, "_data"}, {24'd0, data}, {24'd0, want});
      cyc(hold * SCAN_DIV);
      key_down = 1'b0;
      cyc(2 * SCAN_DIV);
      exp_armed = 1'b0;
      wait_state({name, "_to_scan"}, ST_SCAN);
      check({name, "_next_col"}, {28'd0, cols}, {28'd0, want_cols});
      got = pulse_cnt - base;
      check({name, "_pulses"}, got, model_pulses(hold));
   endtask

   initial begin
      int         got;
      int         base;
      int         hold;
      logic [7:0] pre;
      logic [3:0] m;
      logic [1:0] c;

      // Reset with all rows active and en high.
      nRST = 1'b0;
      en = 1'b1;
      glitch_rows = 4'hF;
      cyc(1);
      mon_on = 1'b1;
      cyc(1);
      check("reset_cols", {28'd0, cols}, 32'd0);
      check("reset_data", {24'd0, data}, 32'd0);
      check("reset_keyvalid", {31'd0, keyvalid}, 32'd0);
      check("reset_state", {29'd0, dbg_state}, {29'd0, ST_SCAN});
      nRST = 1'b1;
      glitch_rows = 4'h0;
      cyc(1);
      check("reset_release_cols", {28'd0, cols}, 32'd1);

      // Clean press of "5" held a long time.
      do_press("clean_5", 4'b0010, 2'd1, 40, got);
      check("clean_5_literal", {24'd0, data}, 32'h35);
      check("clean_5_count", got, CLEAN_EXP);

      // Single-tick bounce on row2 while col0 is driven.
      pre  = data;
      base = pulse_cnt;
      wait_col0("bounce_col0");
      glitch_rows = 4'b0100;
      cyc(SCAN_DIV);
      glitch_rows = 4'h0;
      cyc(10 * SCAN_DIV);
      check("bounce_pulses", pulse_cnt - base, 32'd0);
      check("bounce_data", {24'd0, data}, {24'd0, pre});

      // Map corners and a multi-row press.
      do_press("r3c0", 4'b1000, 2'd0, 3, got);
      check("r3c0_literal", {24'd0, data}, 32'h2A);
      check("r3c0_count", got, 1);
      do_press("r3c2", 4'b1000, 2'd2, 3, got);
      check("r3c2_literal", {24'd0, data}, 32'h23);
      check("r3c2_count", got, 1);
      do_press("r0c3", 4'b0001, 2'd3, 3, got);
      check("r0c3_literal", {24'd0, data}, 32'h41);
      check("r0c3_count", got, 1);
      do_press("r3c3", 4'b1000, 2'd3, 3, got);
      check("r3c3_literal", {24'd0, data}, 32'h44);
      check("r3c3_count", got, 1);
      do_press("multi_row", 4'b1010, 2'd2, 3, got);
      check("multi_row_literal", {24'd0, data}, 32'h36);

      // Drop en during DEBOUNCE, then re-enable with the key still held.
      pre       = data;
      base      = pulse_cnt;
      exp_armed = 1'b0;
      key_mask  = 4'b0001;
      key_col   = 2'd0;
      key_down  = 1'b1;
      wait_state("en_abort_debounce", ST_DEBOUNCE);
      en = 1'b0;
      cyc(1);
      check("en_abort_cols", {28'd0, cols}, 32'd0);
      check("en_abort_state", {29'd0, dbg_state}, {29'd0, ST_SCAN});
      cyc(6 * SCAN_DIV);
      check("en_abort_pulses", pulse_cnt - base, 32'd0);
      check("en_abort_data", {24'd0, data}, {24'd0, pre});
      exp_data  = 8'h31;
      exp_armed = 1'b1;
      en = 1'b1;
      cyc(1);
      check("en_restart_col0", {28'd0, cols}, 32'd1);
      wait_pulses("en_restart_pulse", base + 1);
      check("en_restart_literal", {24'd0, data}, 32'h31);
      key_down = 1'b0;
      cyc(2 * SCAN_DIV);
      exp_armed = 1'b0;
      wait_state("en_restart_to_scan", ST_SCAN);

      // Reset while a press sits in HOLD.
      base      = pulse_cnt;
      exp_data  = 8'h38;
      exp_armed = 1'b1;
      key_mask  = 4'b0100;
      key_col   = 2'd1;
      key_down  = 1'b1;
      wait_pulses("rst_hold_pulse", base + 1);
      cyc(2 * SCAN_DIV);
      exp_armed = 1'b0;
      key_down  = 1'b0;
      nRST = 1'b0;
      cyc(2);
      check("rst_hold_state", {29'd0, dbg_state}, {29'd0, ST_SCAN});
      check("rst_hold_data", {24'd0, data}, 32'd0);
      check("rst_hold_keyvalid", {31'd0, keyvalid}, 32'd0);
      check("rst_hold_cols", {28'd0, cols}, 32'd0);
      nRST = 1'b1;
      cyc(15 * SCAN_DIV);
      check("rst_hold_no_pulse", pulse_cnt - base, 32'd1);
      check("rst_hold_data_kept", {24'd0, data}, 32'd0);

      // Hold "1" long enough for auto-repeat to matter.
      do_press("repeat_1", 4'b0001, 2'd0, 18, got);
      check("repeat_1_literal", {24'd0, data}, 32'h31);
      check("repeat_1_count", got, REPEAT_EXP);

      // Random presses, hold lengths kept off repeat boundaries.
      for (int i = 0; i < 10; i++) begin
         m    = 4'($urandom_range(1, 15));
         c    = 2'($urandom_range(0, 3));
         hold = $urandom_range(2, 24);
         if (((hold + 1) % 8) == 0) hold++;
         do_press("rand", m, c, hold, got);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
